// File: rtl/distance_accum_4cen.sv
// distance_accum_4cen
//   Streams DIM elements of an input vector x together with the matching
//   elements of four centroids and accumulates the L1 distance of x to each
//   centroid in parallel. Accumulators saturate at 16'hFFFF. The result is
//   held on d_* with a valid/ready handshake until downstream consumes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a new computation (honoured only in IDLE)
//   in_valid   x / mu_* carry a valid element this cycle
//   in_ready   block accepts an element this cycle (ACCUM)
//   x          input-vector element, unsigned 16 bit
//   mu_00..11  current element of centroids 0..3, unsigned 16 bit
//   elem_idx   index of the element expected next
//   out_valid  d_* hold a completed result (DONE)
//   out_ready  downstream consumes the result
//   d_00..11   L1 distance of x to centroids 0..3
module distance_accum_4cen #(
  parameter int unsigned DIM = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] mu_00,
  input  logic [15:0] mu_01,
  input  logic [15:0] mu_10,
  input  logic [15:0] mu_11,
  output logic [7:0]  elem_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d_00,
  output logic [15:0] d_01,
  output logic [15:0] d_10,
  output logic [15:0] d_11
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DIM - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] acc [4];
  logic [15:0] mu  [4];
  logic        beat;
  logic        last_beat;

  assign mu[0] = mu_00;
  assign mu[1] = mu_01;
  assign mu[2] = mu_10;
  assign mu[3] = mu_11;

  assign beat      = (state == ACCUM) && in_valid;
  assign last_beat = beat && (elem_idx == LAST_IDX);

  // |xv - mv| is formed on 17 bits so x < mu yields a negative value that is
  // negated back to a magnitude (always <= 16'hFFFF). The 17-bit sum carries
  // into bit 16 exactly when the 16-bit accumulator would overflow; a value
  // already at 16'hFFFF therefore stays there for any further addend.
  function automatic logic [15:0] sat_accum(input logic [15:0] acc_in,
                                            input logic [15:0] xv,
                                            input logic [15:0] mv);
    logic [16:0] diff;
    logic [16:0] mag;
    logic [16:0] sum;
    diff = {1'b0, xv} - {1'b0, mv};
    mag  = diff[16] ? (~diff + 17'd1) : diff;
    sum  = {1'b0, acc_in} + mag;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs decode the state register only, so no input reaches an output
  // without passing through a flop.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // Accumulators and element index. elem_idx stops at LAST_IDX on the final
  // beat and holds there through DONE and IDLE until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) acc[k] <= '0;
      elem_idx <= '0;
    end else if ((state == IDLE) && start) begin
      for (int unsigned k = 0; k < 4; k++) acc[k] <= '0;
      elem_idx <= '0;
    end else if (beat) begin
      for (int unsigned k = 0; k < 4; k++) acc[k] <= sat_accum(acc[k], x, mu[k]);
      if (elem_idx != LAST_IDX) elem_idx <= elem_idx + 8'd1;
    end
  end

  assign d_00 = acc[0];
  assign d_01 = acc[1];
  assign d_10 = acc[2];
  assign d_11 = acc[3];

endmodule
